// File: rtl/vending_pkg.sv
// Shared types and coin helpers for the multi-product vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vm_state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

  // Value of a coin code given the three denominations.
  function automatic int coin_value(input logic [1:0] code, input int c1, input int c2,
                                    input int c3);
    case (code)
      COIN_1:  return c1;
      COIN_2:  return c2;
      COIN_3:  return c3;
      default: return 0;
    endcase
  endfunction

  // Largest coin that does not exceed the remaining credit.
  function automatic logic [1:0] greedy_coin(input int credit, input int c1, input int c2,
                                             input int c3);
    if (credit >= c3)      return COIN_3;
    else if (credit >= c2) return COIN_2;
    else if (credit >= c1) return COIN_1;
    else                   return COIN_NONE;
  endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-product stock counters with decrement on vend and bulk restock.
module vm_stock_bank #(
  parameter int NUM_PRODUCTS = 4,
  parameter int SEL_W        = 2,
  parameter int STOCK_W      = 4,
  parameter int STOCK_INIT   = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dec_i,
  input  logic [SEL_W-1:0]        dec_id_i,
  input  logic                    restock_i,
  output logic [NUM_PRODUCTS-1:0] empty_o
);

  logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];

  // Counters: restock reloads all, a vend takes one from the selected product.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NUM_PRODUCTS; p++) stock_q[p] <= STOCK_W'(STOCK_INIT);
    end else if (restock_i) begin
      for (int p = 0; p < NUM_PRODUCTS; p++) stock_q[p] <= STOCK_W'(STOCK_INIT);
    end else if (dec_i) begin
      for (int p = 0; p < NUM_PRODUCTS; p++) begin
        if (dec_id_i == SEL_W'(p) && stock_q[p] != '0) stock_q[p] <= stock_q[p] - STOCK_W'(1);
      end
    end
  end

  // Empty flags feed the sold-out decode in the top level.
  always_comb begin
    for (int p = 0; p < NUM_PRODUCTS; p++) empty_o[p] = (stock_q[p] == '0);
  end

endmodule

// File: rtl/vending_machine_mp.sv
// Multi-product vending controller: credit collection, vend, greedy change/refund.
module vending_machine_mp
  import vending_pkg::*;
#(
  parameter int                                NUM_PRODUCTS   = 4,
  parameter int                                SEL_W          = 2,
  parameter int                                CREDIT_W       = 8,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]  PRICE_LIST     = {8'd50, 8'd35, 8'd25, 8'd15},
  parameter int                                COIN1_VAL      = 5,
  parameter int                                COIN2_VAL      = 10,
  parameter int                                COIN3_VAL      = 25,
  parameter int                                MAX_CREDIT     = 100,
  parameter int                                STOCK_W        = 4,
  parameter int                                STOCK_INIT     = 10,
  parameter int                                TIMEOUT_CYCLES = 6144
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  input  logic                restock,
  input  logic                change_ready,
  output logic                vend,
  output logic [SEL_W-1:0]    vend_id,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [1:0]          change_coin,
  output logic                coin_reject,
  output logic                sold_out,
  output logic                busy
);

  localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  vm_state_e           state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [TMR_W-1:0]    timer_q;
  logic                vend_q;
  logic [SEL_W-1:0]    vend_id_q;
  logic                change_valid_q;
  logic [1:0]          change_coin_q;
  logic                coin_reject_q;
  logic                busy_q;

  logic [NUM_PRODUCTS-1:0] empty;
  logic [CREDIT_W-1:0]     coin_val;
  logic                    coin_fits;
  logic [CREDIT_W-1:0]     price_sel;
  logic [CREDIT_W-1:0]     price_vend;
  logic [CREDIT_W-1:0]     vend_rem_d;
  logic [CREDIT_W-1:0]     change_rem_d;
  logic [CREDIT_W:0]       credit_sum;

  vm_stock_bank #(
    .NUM_PRODUCTS (NUM_PRODUCTS),
    .SEL_W        (SEL_W),
    .STOCK_W      (STOCK_W),
    .STOCK_INIT   (STOCK_INIT)
  ) u_stock (
    .clk_i     (clk),
    .rst_i     (rst),
    .dec_i     (state_q == VEND),
    .dec_id_i  (vend_id_q),
    .restock_i (restock && state_q == IDLE),
    .empty_o   (empty)
  );

  // Price lookups, sold-out decode and the remaining-credit arithmetic.
  always_comb begin
    coin_val  = CREDIT_W'(coin_value(coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));
    // One extra bit so a near-ceiling credit cannot wrap past the limit.
    credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
    coin_fits  = credit_sum <= (CREDIT_W + 1)'(MAX_CREDIT);
    price_sel  = '0;
    price_vend = '0;
    sold_out   = 1'b1;
    for (int p = 0; p < NUM_PRODUCTS; p++) begin
      if (sel == SEL_W'(p)) begin
        price_sel = PRICE_LIST[p*CREDIT_W +: CREDIT_W];
        sold_out  = empty[p];
      end
      if (vend_id_q == SEL_W'(p)) price_vend = PRICE_LIST[p*CREDIT_W +: CREDIT_W];
    end
    vend_rem_d   = credit_q - price_vend;
    change_rem_d = credit_q -
                   CREDIT_W'(coin_value(change_coin_q, COIN1_VAL, COIN2_VAL, COIN3_VAL));
  end

  // Main FSM with registered outputs, credit register and idle timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      timer_q        <= '0;
      vend_q         <= 1'b0;
      vend_id_q      <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= COIN_NONE;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      vend_q        <= 1'b0;
      coin_reject_q <= 1'b0;
      timer_q       <= '0;
      case (state_q)
        IDLE: begin
          if (coin != COIN_NONE) begin
            if (coin_fits) begin
              credit_q <= credit_q + coin_val;
              state_q  <= COLLECT;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (cancel || timer_q == TMR_LAST) begin
            coin_reject_q  <= (coin != COIN_NONE);
            state_q        <= CHANGE;
            busy_q         <= 1'b1;
            change_valid_q <= 1'b1;
            change_coin_q  <= greedy_coin(32'(credit_q), COIN1_VAL, COIN2_VAL, COIN3_VAL);
          end else begin
            timer_q <= timer_q + TMR_W'(1);
            if (coin != COIN_NONE) begin
              if (coin_fits) begin
                credit_q <= credit_q + coin_val;
                timer_q  <= '0;
              end else begin
                coin_reject_q <= 1'b1;
              end
            end
            // Decision uses the credit registered before this edge.
            if (credit_q >= price_sel && !sold_out) begin
              state_q   <= VEND;
              vend_q    <= 1'b1;
              vend_id_q <= sel;
              busy_q    <= 1'b1;
            end
          end
        end
        VEND: begin
          coin_reject_q <= (coin != COIN_NONE);
          credit_q      <= vend_rem_d;
          if (vend_rem_d != '0) begin
            state_q        <= CHANGE;
            change_valid_q <= 1'b1;
            change_coin_q  <= greedy_coin(32'(vend_rem_d), COIN1_VAL, COIN2_VAL, COIN3_VAL);
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        CHANGE: begin
          coin_reject_q <= (coin != COIN_NONE);
          if (change_valid_q && change_ready) begin
            credit_q <= change_rem_d;
            if (change_rem_d == '0) begin
              state_q        <= IDLE;
              busy_q         <= 1'b0;
              change_valid_q <= 1'b0;
              change_coin_q  <= COIN_NONE;
            end else begin
              change_coin_q <= greedy_coin(32'(change_rem_d), COIN1_VAL, COIN2_VAL, COIN3_VAL);
            end
          end else if (!change_valid_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vend         = vend_q;
  assign vend_id      = vend_id_q;
  assign credit       = credit_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign coin_reject  = coin_reject_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_machine_mp.sv
// Bench for vending_machine_mp: directed scenarios plus randomized purchases
// checked against a credit/stock model.
module tb_vending_machine_mp;

  localparam int STOCK_INIT_TB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] coin;
  logic [1:0] sel;
  logic       cancel;
  logic       restock;
  logic       change_ready;
  logic       vend;
  logic [1:0] vend_id;
  logic [7:0] credit;
  logic       change_valid;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       sold_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int m_stock[4];
  int price_tab[4] = '{15, 25, 35, 50};

  always #5 clk = ~clk;

  vending_machine_mp #(.STOCK_INIT(STOCK_INIT_TB)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin         (coin),
    .sel          (sel),
    .cancel       (cancel),
    .restock      (restock),
    .change_ready (change_ready),
    .vend         (vend),
    .vend_id      (vend_id),
    .credit       (credit),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .coin_reject  (coin_reject),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  function automatic int cval(input logic [1:0] c);
    case (c)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 25;
      default: return 0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stock_reset();
    for (int p = 0; p < 4; p++) m_stock[p] = STOCK_INIT_TB;
  endtask

  // Collects the returned coins and checks they form the largest-first
  // decomposition of the amount owed, with the coin held under backpressure.
  task automatic drain(input int amount, input bit rnd);
    int         owed;
    int         cyc;
    int         expect_q[$];
    logic [1:0] held;
    bit         r;
    owed = amount;
    while (owed >= 25) begin expect_q.push_back(3); owed -= 25; end
    while (owed >= 10) begin expect_q.push_back(2); owed -= 10; end
    while (owed >= 5)  begin expect_q.push_back(1); owed -= 5; end
    owed = amount;
    cyc  = 0;
    while (expect_q.size() > 0 && cyc < 100) begin
      checks++;
      if (change_valid !== 1'b1 || change_coin !== 2'(expect_q[0]) || credit !== 8'(owed)) begin
        errors++;
        $display("FAIL change_step: valid=%0b coin=%0d credit=%0d, expected valid=1 coin=%0d credit=%0d",
                 change_valid, change_coin, credit, expect_q[0], owed);
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      change_ready = r;
      held = change_coin;
      step();
      cyc++;
      if (r) begin
        owed -= cval(2'(expect_q[0]));
        void'(expect_q.pop_front());
      end else begin
        checks++;
        if (change_valid !== 1'b1 || change_coin !== held) begin
          errors++;
          $display("FAIL change_hold: valid=%0b coin=%0d, expected valid=1 coin=%0d",
                   change_valid, change_coin, held);
        end
      end
    end
    change_ready = 1'b0;
    checks++;
    if (expect_q.size() != 0) begin
      errors++;
      $display("FAIL change_bound: %0d coins still owed after %0d cycles, expected 0", expect_q.size(), cyc);
    end
    checks++;
    if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL change_done: valid=%0b credit=%0d busy=%0b, expected 0/0/0", change_valid, credit, busy);
    end
  endtask

  // Random-coin purchase of product s, then change collection.
  task automatic buy(input int s);
    int         m_credit;
    logic [1:0] c;
    sel = 2'(s);
    m_credit = 0;
    while (m_credit < price_tab[s]) begin
      c = 2'($urandom_range(1, 3));
      coin = c;
      step();
      coin = 2'b00;
      m_credit += cval(c);
      checks++;
      if (credit !== 8'(m_credit) || vend !== 1'b0 || coin_reject !== 1'b0) begin
        errors++;
        $display("FAIL collect: credit=%0d vend=%0b reject=%0b, expected credit=%0d vend=0 reject=0",
                 credit, vend, coin_reject, m_credit);
      end
    end
    step();
    checks++;
    if (vend !== 1'b1 || vend_id !== 2'(s) || busy !== 1'b1) begin
      errors++;
      $display("FAIL vend_pulse: vend=%0b id=%0d busy=%0b, expected vend=1 id=%0d busy=1", vend, vend_id, busy, s);
    end
    step();
    m_credit -= price_tab[s];
    m_stock[s]--;
    checks++;
    if (vend !== 1'b0 || credit !== 8'(m_credit)) begin
      errors++;
      $display("FAIL vend_exit: vend=%0b credit=%0d, expected vend=0 credit=%0d", vend, credit, m_credit);
    end
    if (m_credit > 0) drain(m_credit, 1'b1);
    else begin
      checks++;
      if (change_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL exact_idle: valid=%0b busy=%0b, expected 0/0", change_valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (vend !== 1'b0 || vend_id !== 2'd0 || credit !== 8'd0 || change_valid !== 1'b0 ||
        change_coin !== 2'd0 || coin_reject !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: vend=%0b id=%0d credit=%0d cv=%0b cc=%0d rej=%0b busy=%0b, expected all 0",
               vend, vend_id, credit, change_valid, change_coin, coin_reject, busy);
    end
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (sold_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_sold_out: sel=%0d sold_out=%0b, expected 0", s, sold_out);
      end
    end
  endtask

  task automatic test_exact_change();
    sel = 2'd0;
    coin = 2'b10; step(); coin = 2'b00;
    checks++;
    if (credit !== 8'd10 || vend !== 1'b0) begin
      errors++; $display("FAIL ec_coin1: credit=%0d vend=%0b, expected 10/0", credit, vend);
    end
    coin = 2'b10; step(); coin = 2'b00;
    checks++;
    if (credit !== 8'd20 || vend !== 1'b0) begin
      errors++; $display("FAIL ec_coin2: credit=%0d vend=%0b, expected 20/0", credit, vend);
    end
    step();
    checks++;
    if (vend !== 1'b1 || vend_id !== 2'd0 || credit !== 8'd20 || busy !== 1'b1) begin
      errors++; $display("FAIL ec_vend: vend=%0b id=%0d credit=%0d busy=%0b, expected 1/0/20/1", vend, vend_id, credit, busy);
    end
    step();
    checks++;
    if (vend !== 1'b0 || credit !== 8'd5 || change_valid !== 1'b1 || change_coin !== 2'b01) begin
      errors++; $display("FAIL ec_change: vend=%0b credit=%0d cv=%0b cc=%0d, expected 0/5/1/1", vend, credit, change_valid, change_coin);
    end
    change_ready = 1'b1; step(); change_ready = 1'b0;
    checks++;
    if (change_valid !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL ec_idle: cv=%0b credit=%0d busy=%0b, expected 0/0/0", change_valid, credit, busy);
    end
    m_stock[0]--;
  endtask

  task automatic test_backpressure();
    sel = 2'd2;
    coin = 2'b11; step();
    coin = 2'b11; step(); coin = 2'b00;
    checks++;
    if (credit !== 8'd50) begin
      errors++; $display("FAIL bp_credit: credit=%0d, expected 50", credit);
    end
    step();
    checks++;
    if (vend !== 1'b1 || vend_id !== 2'd2) begin
      errors++; $display("FAIL bp_vend: vend=%0b id=%0d, expected 1/2", vend, vend_id);
    end
    step();
    m_stock[2]--;
    coin = 2'b01;
    step();
    coin = 2'b00;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (change_valid !== 1'b1 || change_coin !== 2'b10 || credit !== 8'd15 || coin_reject !== (i == 0)) begin
        errors++;
        $display("FAIL bp_hold: cycle=%0d cv=%0b cc=%0d credit=%0d rej=%0b, expected 1/2/15/%0b",
                 i, change_valid, change_coin, credit, coin_reject, i == 0);
      end
      if (i < 2) step();
    end
    drain(15, 1'b0);
  endtask

  task automatic test_cancel();
    sel = 2'd3;
    coin = 2'b11; step();
    coin = 2'b01; step();
    coin = 2'b10; cancel = 1'b1; step();
    coin = 2'b00; cancel = 1'b0;
    checks++;
    if (coin_reject !== 1'b1 || change_valid !== 1'b1 || change_coin !== 2'b11 || credit !== 8'd30 || vend !== 1'b0) begin
      errors++;
      $display("FAIL cancel_start: rej=%0b cv=%0b cc=%0d credit=%0d vend=%0b, expected 1/1/3/30/0",
               coin_reject, change_valid, change_coin, credit, vend);
    end
    drain(30, 1'b1);
  endtask

  task automatic test_timeout();
    bit seen;
    sel  = 2'd3;
    seen = 1'b0;
    coin = 2'b10; step(); coin = 2'b00;
    for (int i = 0; i < 5999; i++) begin
      step();
      if (change_valid || vend) seen = 1'b1;
    end
    coin = 2'b11; step(); coin = 2'b00;
    checks++;
    if (credit !== 8'd35) begin
      errors++; $display("FAIL to_credit: credit=%0d, expected 35", credit);
    end
    for (int i = 0; i < 6143; i++) begin
      step();
      if (change_valid || vend) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL to_early: refund or vend seen=%0b before timeout, expected 0", seen);
    end
    step();
    checks++;
    if (change_valid !== 1'b1 || change_coin !== 2'b11 || busy !== 1'b1) begin
      errors++; $display("FAIL to_fire: cv=%0b cc=%0d busy=%0b, expected 1/3/1", change_valid, change_coin, busy);
    end
    drain(35, 1'b0);
  endtask

  task automatic test_random();
    int s;
    for (int n = 0; n < 16; n++) begin
      s = $urandom_range(0, 3);
      sel = 2'(s);
      #1;
      checks++;
      if (sold_out !== (m_stock[s] == 0)) begin
        errors++; $display("FAIL rnd_sold_out: sel=%0d sold_out=%0b, expected %0b", s, sold_out, m_stock[s] == 0);
      end
      if (m_stock[s] == 0) begin
        coin = 2'b11; step(); coin = 2'b00;
        step(); step();
        checks++;
        if (vend !== 1'b0 || credit !== 8'd25) begin
          errors++; $display("FAIL rnd_blocked: vend=%0b credit=%0d, expected 0/25", vend, credit);
        end
        cancel = 1'b1; step(); cancel = 1'b0;
        drain(25, 1'b1);
      end else begin
        buy(s);
      end
    end
  endtask

  task automatic test_sold_out_overflow();
    restock = 1'b1; step(); restock = 1'b0;
    stock_reset();
    for (int k = 0; k < STOCK_INIT_TB; k++) buy(1);
    sel = 2'd1;
    #1;
    checks++;
    if (sold_out !== 1'b1) begin
      errors++; $display("FAIL so_flag: sold_out=%0b, expected 1", sold_out);
    end
    for (int k = 1; k <= 4; k++) begin
      coin = 2'b11;
      restock = (k == 2);
      step();
      coin = 2'b00; restock = 1'b0;
      checks++;
      if (credit !== 8'(25 * k) || vend !== 1'b0 || sold_out !== 1'b1) begin
        errors++;
        $display("FAIL so_collect: k=%0d credit=%0d vend=%0b sold_out=%0b, expected %0d/0/1",
                 k, credit, vend, sold_out, 25 * k);
      end
    end
    coin = 2'b11; step(); coin = 2'b00;
    checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd100) begin
      errors++; $display("FAIL ovf_reject: rej=%0b credit=%0d, expected 1/100", coin_reject, credit);
    end
    step();
    checks++;
    if (coin_reject !== 1'b0 || vend !== 1'b0) begin
      errors++; $display("FAIL ovf_pulse: rej=%0b vend=%0b, expected 0/0", coin_reject, vend);
    end
    cancel = 1'b1; step(); cancel = 1'b0;
    change_ready = 1'b1; step(); change_ready = 1'b0;
    checks++;
    if (change_valid !== 1'b1 || credit !== 8'd75 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_change: cv=%0b credit=%0d busy=%0b, expected 1/75/1", change_valid, credit, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (vend !== 1'b0 || credit !== 8'd0 || change_valid !== 1'b0 || change_coin !== 2'd0 ||
        coin_reject !== 1'b0 || busy !== 1'b0 || sold_out !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: vend=%0b credit=%0d cv=%0b cc=%0d rej=%0b busy=%0b so=%0b, expected all 0",
               vend, credit, change_valid, change_coin, coin_reject, busy, sold_out);
    end
    @(negedge clk);
    rst = 1'b0;
    stock_reset();
    step();
    checks++;
    if (credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset: credit=%0d cv=%0b busy=%0b, expected 0/0/0", credit, change_valid, busy);
    end
  endtask

  task automatic test_restock();
    for (int k = 0; k < STOCK_INIT_TB; k++) buy(1);
    sel = 2'd1;
    #1;
    checks++;
    if (sold_out !== 1'b1) begin
      errors++; $display("FAIL rs_empty: sold_out=%0b, expected 1", sold_out);
    end
    restock = 1'b1; step(); restock = 1'b0;
    stock_reset();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (sold_out !== 1'b0) begin
        errors++; $display("FAIL rs_reload: sel=%0d sold_out=%0b, expected 0", s, sold_out);
      end
    end
    buy(1);
  endtask

  initial begin
    rst = 1'b1;
    coin = 2'b00; sel = 2'd0; cancel = 1'b0; restock = 1'b0; change_ready = 1'b0;
    stock_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();
    test_reset();
    test_exact_change();
    test_backpressure();
    test_cancel();
    test_timeout();
    test_random();
    test_sold_out_overflow();
    test_restock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
